// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - shared types and constants for the IO bus controller
//
// Contents:
//   busState_t          2-bit FSM state encoding (IDLE, DECODE, COMMIT, HOLD)
//   DefaultBaseAddress  IO address of port 0 unless overridden
//   DefaultNumPorts     default number of output ports
//   DefaultStatusOffset offset of the status register from BaseAddress

package io_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    COMMIT = 2'd2,
    HOLD   = 2'd3
  } busState_t;

  localparam int DefaultBaseAddress  = 60;
  localparam int DefaultNumPorts     = 4;
  // The status register sits directly after the last port.
  localparam int DefaultStatusOffset = DefaultNumPorts;

endpackage

// File: rtl/io_addr_decoder.sv
// rtl/io_addr_decoder.sv - combinational IO address decoder
//
// Ports:
//   address    in   AddrBits  IO address to decode
//   portSel    out  NumPorts  one-hot select, bit k for BaseAddress+k
//   statusHit  out  1         address equals BaseAddress+StatusOffset
//   mapped     out  1         address hits a port or the status register

module io_addr_decoder
  import io_bus_pkg::*;
#(
  parameter int NumPorts     = DefaultNumPorts,
  parameter int BaseAddress  = DefaultBaseAddress,
  parameter int AddrBits     = 9,
  parameter int StatusOffset = DefaultStatusOffset
) (
  input  logic [AddrBits-1:0] address,
  output logic [NumPorts-1:0] portSel,
  output logic                statusHit,
  output logic                mapped
);

  logic [31:0] addrExt;

  // Compare in 32 bits: a target above 2**AddrBits-1 can never match the
  // zero-extended address, so map entries never wrap around.
  always_comb begin
    addrExt = 32'(address);
    portSel = '0;
    for (int k = 0; k < NumPorts; k++) begin
      if (addrExt == $unsigned(BaseAddress + k)) begin
        portSel[k] = 1'b1;
      end
    end
    statusHit = (addrExt == $unsigned(BaseAddress + StatusOffset));
    mapped    = (|portSel) | statusHit;
  end

endmodule

// File: rtl/io_bus_controller.sv
// rtl/io_bus_controller.sv - CPU IO write/read controller for output ports
//
// Ports:
//   CLK          in   1                   clock, all state on rising edge
//   Reset        in   1                   synchronous active-high reset
//   AddressIO    in   AddrBits            CPU IO address
//   DataFromCPU  in   32                  CPU write data
//   WriteIO      in   1                   CPU write request level
//   DataToCPU    out  32                  registered read-back data
//   PortIn       in   NumPorts*PortWidth  per-port input values
//   PortOut      out  NumPorts*PortWidth  per-port output registers
//   WriteStrobe  out  NumPorts            one-cycle pulse per committed port
//   Busy         out  1                   transaction in progress
//   ErrUnmapped  out  1                   sticky unmapped-write flag

module io_bus_controller
  import io_bus_pkg::*;
#(
  parameter int NumPorts    = 4,
  parameter int PortWidth   = 31,
  parameter int BaseAddress = DefaultBaseAddress,
  parameter int AddrBits    = 9
) (
  input  logic                          CLK,
  input  logic                          Reset,
  input  logic [AddrBits-1:0]           AddressIO,
  input  logic [31:0]                   DataFromCPU,
  input  logic                          WriteIO,
  output logic [31:0]                   DataToCPU,
  input  logic [NumPorts*PortWidth-1:0] PortIn,
  output logic [NumPorts*PortWidth-1:0] PortOut,
  output logic [NumPorts-1:0]           WriteStrobe,
  output logic                          Busy,
  output logic                          ErrUnmapped
);

  busState_t             state;
  busState_t             stateNext;
  logic                  writeIoQ;
  logic                  latchEn;
  logic                  commitEn;
  logic [AddrBits-1:0]   latchedAddr;
  logic [31:0]           latchedData;

  logic [NumPorts-1:0]   wrPortSel;
  logic                  wrStatusHit;
  logic                  wrMapped;
  logic [NumPorts-1:0]   rdPortSel;
  logic                  rdStatusHit;
  logic                  rdMapped;
  logic [31:0]           readMux;

  // Bits that are deliberately not consumed (upper data bits when
  // PortWidth < 32, and the read-path mapped flag).
  logic                  unusedBits;
  assign unusedBits = ^{latchedData, rdMapped};

  // Write path decodes the address captured at the start of the transaction.
  io_addr_decoder #(
    .NumPorts    (NumPorts),
    .BaseAddress (BaseAddress),
    .AddrBits    (AddrBits),
    .StatusOffset(NumPorts)
  ) u_wr_decoder (
    .address  (latchedAddr),
    .portSel  (wrPortSel),
    .statusHit(wrStatusHit),
    .mapped   (wrMapped)
  );

  // Read path decodes the live address every cycle.
  io_addr_decoder #(
    .NumPorts    (NumPorts),
    .BaseAddress (BaseAddress),
    .AddrBits    (AddrBits),
    .StatusOffset(NumPorts)
  ) u_rd_decoder (
    .address  (AddressIO),
    .portSel  (rdPortSel),
    .statusHit(rdStatusHit),
    .mapped   (rdMapped)
  );

  // State register, edge detector and transaction latch. writeIoQ resets
  // high so a WriteIO level held across reset release is not seen as a
  // fresh rising edge.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= IDLE;
      writeIoQ    <= 1'b1;
      latchedAddr <= '0;
      latchedData <= '0;
    end else begin
      state    <= stateNext;
      writeIoQ <= WriteIO;
      if (latchEn) begin
        latchedAddr <= AddressIO;
        latchedData <= DataFromCPU;
      end
    end
  end

  always_comb begin
    stateNext = state;
    latchEn   = 1'b0;
    commitEn  = 1'b0;
    case (state)
      IDLE: begin
        if (WriteIO && !writeIoQ) begin
          stateNext = DECODE;
          latchEn   = 1'b1;
        end
      end
      DECODE: begin
        stateNext = COMMIT;
      end
      COMMIT: begin
        stateNext = HOLD;
        commitEn  = 1'b1;
      end
      HOLD: begin
        // Stay here until WriteIO drops: one commit per high period.
        if (!WriteIO) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign Busy = (state != IDLE);

  // Commit datapath. Reset has priority, so a reset landing on the COMMIT
  // edge drops the transaction without touching PortOut or the strobes.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      PortOut     <= '0;
      WriteStrobe <= '0;
      ErrUnmapped <= 1'b0;
    end else begin
      WriteStrobe <= '0;
      if (commitEn) begin
        if (!wrMapped) begin
          ErrUnmapped <= 1'b1;
        end else if (wrStatusHit) begin
          ErrUnmapped <= 1'b0;
        end else begin
          WriteStrobe <= wrPortSel;
          for (int k = 0; k < NumPorts; k++) begin
            if (wrPortSel[k]) begin
              PortOut[k*PortWidth +: PortWidth] <= latchedData[PortWidth-1:0];
            end
          end
        end
      end
    end
  end

  // Read-back mux, zero-extending the selected port slice.
  always_comb begin
    readMux = '0;
    if (rdStatusHit) begin
      readMux = {30'b0, Busy, ErrUnmapped};
    end else begin
      for (int k = 0; k < NumPorts; k++) begin
        if (rdPortSel[k]) begin
          readMux[PortWidth-1:0] = PortIn[k*PortWidth +: PortWidth];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      DataToCPU <= '0;
    end else begin
      DataToCPU <= readMux;
    end
  end

endmodule

// File: tb/tb_io_bus_controller.sv
// tb/tb_io_bus_controller.sv - directed self-checking bench for io_bus_controller

module tb_io_bus_controller;

  localparam int NP = 4;
  localparam int PW = 31;
  localparam int AB = 9;

  logic              CLK;
  logic              Reset;
  logic [AB-1:0]     AddressIO;
  logic [31:0]       DataFromCPU;
  logic              WriteIO;
  logic [31:0]       DataToCPU;
  logic [NP*PW-1:0]  PortIn;
  logic [NP*PW-1:0]  PortOut;
  logic [NP-1:0]     WriteStrobe;
  logic              Busy;
  logic              ErrUnmapped;

  int total = 0;
  int bad   = 0;

  io_bus_controller #(
    .NumPorts   (NP),
    .PortWidth  (PW),
    .BaseAddress(60),
    .AddrBits   (AB)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .AddressIO  (AddressIO),
    .DataFromCPU(DataFromCPU),
    .WriteIO    (WriteIO),
    .DataToCPU  (DataToCPU),
    .PortIn     (PortIn),
    .PortOut    (PortOut),
    .WriteStrobe(WriteStrobe),
    .Busy       (Busy),
    .ErrUnmapped(ErrUnmapped)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [PW-1:0] portOf(input int k);
    return PortOut[k*PW +: PW];
  endfunction

  // Full write handshake; returns the strobe seen in the commit-result cycle.
  task automatic doWrite(input logic [AB-1:0] a, input logic [31:0] d,
                         output logic [NP-1:0] strobe);
    AddressIO   = a;
    DataFromCPU = d;
    WriteIO     = 1'b1;
    tick();
    tick();
    tick();
    strobe  = WriteStrobe;
    WriteIO = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    WriteIO = 1'b0;
    AddressIO = '0;
    DataFromCPU = '0;
    PortIn = '0;
    tick();
    tick();
    total++; if (PortOut !== '0) begin bad++; $display("FAIL reset_portout got=%h exp=0", PortOut); end
    total++; if (DataToCPU !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", DataToCPU); end
    total++; if (WriteStrobe !== 4'b0) begin bad++; $display("FAIL reset_strobe got=%b exp=0000", WriteStrobe); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    total++; if (ErrUnmapped !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", ErrUnmapped); end
    // WriteIO held high across reset release must not start a transaction.
    AddressIO = 9'd60;
    DataFromCPU = 32'd77;
    WriteIO = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (Busy !== 1'b0 || WriteStrobe !== 4'b0) begin
        bad++; $display("FAIL reset_held_write busy=%b strobe=%b exp busy=0 strobe=0000", Busy, WriteStrobe);
      end
    end
    WriteIO = 1'b0;
    tick();
    total++; if (PortOut !== '0) begin bad++; $display("FAIL reset_held_portout got=%h exp=0", PortOut); end
  endtask

  task automatic test_basic_write();
    AddressIO = 9'd61;
    DataFromCPU = 32'hFFFF_FFFF;
    WriteIO = 1'b1;
    tick();
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL basic_busy_decode got=%b exp=1", Busy); end
    // Inputs change after latching; the transaction must not see them.
    AddressIO = 9'd62;
    DataFromCPU = 32'h0;
    tick();
    total++; if (WriteStrobe !== 4'b0000 || portOf(1) !== 31'h0) begin
      bad++; $display("FAIL basic_early strobe=%b port1=%h exp strobe=0000 port1=0", WriteStrobe, portOf(1));
    end
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL basic_busy_commit got=%b exp=1", Busy); end
    tick();
    total++; if (WriteStrobe !== 4'b0010) begin bad++; $display("FAIL basic_strobe got=%b exp=0010", WriteStrobe); end
    total++; if (portOf(1) !== 31'h7FFF_FFFF) begin bad++; $display("FAIL basic_port1 got=%h exp=7fffffff", portOf(1)); end
    total++; if (portOf(2) !== 31'h0) begin bad++; $display("FAIL basic_port2 got=%h exp=0", portOf(2)); end
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL basic_busy_hold got=%b exp=1", Busy); end
    tick();
    total++; if (WriteStrobe !== 4'b0000) begin bad++; $display("FAIL basic_strobe_once got=%b exp=0000", WriteStrobe); end
    WriteIO = 1'b0;
    tick();
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL basic_busy_idle got=%b exp=0", Busy); end
  endtask

  task automatic test_readback();
    PortIn = '0;
    PortIn[3*PW +: PW] = 31'h1234;
    PortIn[0*PW +: PW] = 31'h7FFF_FFFF;
    AddressIO = 9'd63;
    tick();
    total++; if (DataToCPU !== 32'h0000_1234) begin bad++; $display("FAIL read_port3 got=%h exp=00001234", DataToCPU); end
    AddressIO = 9'd65;
    tick();
    total++; if (DataToCPU !== 32'h0) begin bad++; $display("FAIL read_unmapped got=%h exp=0", DataToCPU); end
    AddressIO = 9'd60;
    tick();
    total++; if (DataToCPU !== 32'h7FFF_FFFF) begin bad++; $display("FAIL read_port0 got=%h exp=7fffffff", DataToCPU); end
    // Status read while a status write is in flight shows Busy=1.
    AddressIO = 9'd64;
    DataFromCPU = 32'h0;
    WriteIO = 1'b1;
    tick();
    tick();
    total++; if (DataToCPU !== 32'h2) begin bad++; $display("FAIL read_status_busy got=%h exp=2", DataToCPU); end
    WriteIO = 1'b0;
    tick();
    tick();
    tick();
    total++; if (DataToCPU !== 32'h0) begin bad++; $display("FAIL read_status_idle got=%h exp=0", DataToCPU); end
  endtask

  task automatic test_long_hold();
    int pulses0;
    int otherPulses;
    pulses0 = 0;
    otherPulses = 0;
    AddressIO = 9'd60;
    DataFromCPU = 32'd5;
    WriteIO = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (WriteStrobe[0]) pulses0++;
      if (WriteStrobe[3:1] != 3'b0) otherPulses++;
    end
    total++; if (pulses0 !== 1 || otherPulses !== 0) begin
      bad++; $display("FAIL hold_pulses got=%0d/%0d exp=1/0", pulses0, otherPulses);
    end
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL hold_busy got=%b exp=1", Busy); end
    total++; if (portOf(0) !== 31'd5) begin bad++; $display("FAIL hold_port0 got=%h exp=5", portOf(0)); end
    WriteIO = 1'b0;
    tick();
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL hold_release got=%b exp=0", Busy); end
  endtask

  task automatic test_unmapped();
    logic [NP-1:0]    s;
    logic [NP*PW-1:0] exp;
    exp = '0;
    exp[0*PW +: PW] = 31'd5;
    exp[1*PW +: PW] = 31'h7FFF_FFFF;
    doWrite(9'd59, 32'h1111_1111, s);
    total++; if (ErrUnmapped !== 1'b1) begin bad++; $display("FAIL unm59_err got=%b exp=1", ErrUnmapped); end
    total++; if (s !== 4'b0 || PortOut !== exp) begin
      bad++; $display("FAIL unm59_ports strobe=%b portout=%h exp strobe=0000 portout=%h", s, PortOut, exp);
    end
    AddressIO = 9'd64;
    tick();
    total++; if (DataToCPU !== 32'h1) begin bad++; $display("FAIL unm_status_read got=%h exp=1", DataToCPU); end
    doWrite(9'd64, 32'h0, s);
    total++; if (ErrUnmapped !== 1'b0 || s !== 4'b0) begin
      bad++; $display("FAIL status_clear err=%b strobe=%b exp err=0 strobe=0000", ErrUnmapped, s);
    end
    doWrite(9'd65, 32'h2222_2222, s);
    total++; if (ErrUnmapped !== 1'b1 || PortOut !== exp) begin
      bad++; $display("FAIL unm65 err=%b portout=%h exp err=1 portout=%h", ErrUnmapped, PortOut, exp);
    end
    // Last port boundary, upper data bit dropped.
    doWrite(9'd63, 32'hABCD_0123, s);
    total++; if (s !== 4'b1000 || portOf(3) !== 31'h2BCD_0123) begin
      bad++; $display("FAIL last_port strobe=%b port3=%h exp strobe=1000 port3=2bcd0123", s, portOf(3));
    end
    total++; if (ErrUnmapped !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", ErrUnmapped); end
  endtask

  task automatic test_reset_abort();
    logic [NP-1:0] s;
    AddressIO = 9'd62;
    DataFromCPU = 32'd9;
    WriteIO = 1'b1;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    total++; if (WriteStrobe !== 4'b0 || PortOut !== '0) begin
      bad++; $display("FAIL abort_commit strobe=%b portout=%h exp strobe=0000 portout=0", WriteStrobe, PortOut);
    end
    total++; if (Busy !== 1'b0 || ErrUnmapped !== 1'b0) begin
      bad++; $display("FAIL abort_state busy=%b err=%b exp 0/0", Busy, ErrUnmapped);
    end
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (WriteStrobe !== 4'b0 || Busy !== 1'b0) begin
        bad++; $display("FAIL abort_no_recommit strobe=%b busy=%b exp 0000/0", WriteStrobe, Busy);
      end
    end
    total++; if (portOf(2) !== 31'h0) begin bad++; $display("FAIL abort_port2 got=%h exp=0", portOf(2)); end
    WriteIO = 1'b0;
    tick();
    doWrite(9'd62, 32'd9, s);
    total++; if (s !== 4'b0100 || portOf(2) !== 31'd9) begin
      bad++; $display("FAIL abort_fresh strobe=%b port2=%h exp strobe=0100 port2=9", s, portOf(2));
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_readback();
    test_long_hold();
    test_unmapped();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_bus_controller.md
IO_BUS_CONTROLLER -- requirements
Module: io_bus_controller

Interface
REQ-001 Parameters SHALL be, one per line:
- NumPorts, 4, number of output ports.
- PortWidth, 31, bits per port, 1..32.
- BaseAddress, 60, IO address of port 0.
- AddrBits, 9, IO address width.
REQ-002 Ports SHALL be, one per line:
- CLK  in  1  single clock; all state on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- AddressIO  in  AddrBits  CPU IO address.
- DataFromCPU  in  32  CPU write data.
- WriteIO  in  1  CPU write request level.
- DataToCPU  out  32  registered read-back data.
- PortIn  in  NumPorts*PortWidth  per-port input values, port k at [k*PortWidth +: PortWidth].
- PortOut  out  NumPorts*PortWidth  per-port output registers, same packing.
- WriteStrobe  out  NumPorts  one-cycle pulse, one bit per port, on commit.
- Busy  out  1  high while a transaction is in progress.
- ErrUnmapped  out  1  sticky flag for a write to an unmapped address.
REQ-003 One clock, CLK; Reset SHALL be synchronous and active-high.

Function
REQ-004 Address map:
- Port k SHALL decode at BaseAddress+k, for 0 <= k < NumPorts.
- Status register SHALL decode at BaseAddress+NumPorts.
- Every other address SHALL be unmapped.
REQ-005 The FSM SHALL have exactly four states: IDLE, DECODE, COMMIT, HOLD.
REQ-006 Leaving IDLE: the FSM SHALL move to DECODE only on a WriteIO rising edge, i.e. WriteIO=1 with registered WriteIO_q=0.
REQ-007 Entering DECODE: AddressIO and DataFromCPU SHALL be latched, so later input changes do not affect the transaction.
REQ-008 DECODE -> COMMIT unconditionally.
REQ-009 In COMMIT:
- Mapped port k: PortOut[k] <= latched data[PortWidth-1:0], and WriteStrobe[k]=1 for exactly this cycle.
- Status address: ErrUnmapped <= 0.
- Unmapped address: ErrUnmapped <= 1, no PortOut change, no strobe.
- Then -> HOLD.
REQ-010 HOLD -> IDLE when WriteIO=0; otherwise remain in HOLD. Exactly one commit per WriteIO high period, however long it lasts.
REQ-011 Latency: rising edge sampled at edge n; DECODE at n+1; PortOut and WriteStrobe valid after edge n+2.
REQ-012 Busy SHALL be 1 in DECODE, COMMIT and HOLD, and 0 in IDLE.
REQ-013 Read-back: DataToCPU SHALL be registered every cycle, independent of FSM state:
- Port address: zero-extended PortIn slice.
- Status address: {30'b0, Busy, ErrUnmapped}.
- Unmapped address: 32'h0.
- One-cycle read latency.
REQ-014 Width rule: DataFromCPU[31:PortWidth] SHALL be ignored; with PortWidth=32 the full word is stored.
REQ-015 Boundary cases:
- Address BaseAddress+NumPorts-1 SHALL map to the last port.
- Address BaseAddress-1 SHALL be unmapped.
- Address arithmetic SHALL not wrap: BaseAddress+k beyond AddrBits is unmapped.

Reset
REQ-016 On Reset=1 the following SHALL be cleared:
- PortOut, DataToCPU, WriteStrobe, ErrUnmapped, Busy all 0.
- FSM -> IDLE.
- Latched address and data -> 0.
REQ-017 Reset SHALL set WriteIO_q=1, so a WriteIO held high across reset release causes no commit until WriteIO has dropped and risen again.
REQ-018 Reset asserted in DECODE or COMMIT SHALL abort the transaction: no PortOut update and no strobe in that cycle.

Structure
REQ-019 Package io_bus_pkg SHALL hold:
- FSM state typedef (2-bit enum).
- Default BaseAddress.
- Status-register offset constant.
REQ-020 One combinational sub-module, io_addr_decoder, SHALL map an address to a one-hot port select, a status hit and a mapped flag; it SHALL be instantiated twice (write path uses the latched address, read path uses live AddressIO).
REQ-021 Target size: about 150-250 lines of RTL.

Verification
REQ-022 WriteIO 0->1 at cycle 10 with AddressIO=61, DataFromCPU=32'hFFFF_FFFF -> PortOut[1]=31'h7FFF_FFFF after edge 12, WriteStrobe=4'b0010 in cycle 12 only, Busy=1 cycles 11-13+.
REQ-023 WriteIO held high for 50 cycles at address 60, data 5 -> exactly one WriteStrobe[0] pulse; Busy stays 1 until WriteIO falls, then 0 the next cycle.
REQ-024 Write to address 59 -> ErrUnmapped=1, all PortOut unchanged; read address 64 -> DataToCPU=32'h1; write to 64 -> ErrUnmapped=0.
REQ-025 Reset pulsed during COMMIT of a write (addr 62, data 9) -> PortOut[2]=0, no strobe; WriteIO still high after reset -> no commit until a fresh rising edge.
REQ-026 PortIn[3]=31'h1234 and AddressIO=63 -> DataToCPU=32'h0000_1234 one cycle later; AddressIO=65 -> 32'h0.
